// File: rtl/ac_motor_gate_pkg.sv
// Shared types and constants for the gate monitor.
// Phase FSM encoding, fault codes, default counter width.
package ac_motor_gate_pkg;

    localparam int CNT_W_DEF = 9;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_HIGH = 2'd1,
        PH_DEAD = 2'd2,
        PH_LOW  = 2'd3
    } phase_state_t;

    localparam logic [1:0] FAULT_NONE  = 2'd0;
    localparam logic [1:0] FAULT_SHOOT = 2'd1;
    localparam logic [1:0] FAULT_DEAD  = 2'd2;
    localparam logic [1:0] FAULT_BOTH  = 2'd3;

endpackage

// File: rtl/ac_motor_gate_phase_monitor.sv
// One bridge leg: tracks high/low/dead state and measures dead time.
// Ports: clk, reset, hi/lo (registered gates), delay -> state,
//        dead_time, strobe, shoot_evt, dead_evt (events are combinational).
module ac_motor_gate_phase_monitor
    import ac_motor_gate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hi,
    input  logic             lo,
    input  logic [7:0]       delay,
    output phase_state_t     state,
    output logic [CNT_W-1:0] dead_time,
    output logic             strobe,
    output logic             shoot_evt,
    output logic             dead_evt
);

    // Comparison width wide enough for both the counter+1 and delay.
    localparam int CW = (CNT_W + 1 > 8) ? CNT_W + 1 : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             from_high;
    logic             take;
    logic [CNT_W-1:0] meas;

    // A measurement is taken only when the leg lands on the side
    // opposite to the one it left.
    always_comb begin
        take = 1'b0;
        meas = '0;
        if (!(hi && lo)) begin
            unique case (state)
                PH_HIGH: take = lo;
                PH_LOW:  take = hi;
                PH_DEAD: begin
                    take = from_high ? lo : hi;
                    meas = cnt;
                end
                default: take = 1'b0;
            endcase
        end
    end

    assign shoot_evt = hi && lo;
    assign dead_evt  = take &&
        ((CW'(meas) + CW'(TOL)) < CW'(delay));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PH_IDLE;
            cnt       <= '0;
            from_high <= 1'b0;
            dead_time <= '0;
            strobe    <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (take) begin
                dead_time <= meas;
                strobe    <= 1'b1;
            end
            if (hi && lo) begin
                state <= PH_IDLE;
            end else begin
                unique case (state)
                    PH_IDLE: begin
                        if (hi)      state <= PH_HIGH;
                        else if (lo) state <= PH_LOW;
                    end
                    PH_HIGH: begin
                        if (!lo && !hi) begin
                            state     <= PH_DEAD;
                            cnt       <= CNT_W'(1);
                            from_high <= 1'b1;
                        end else if (lo) begin
                            state <= PH_LOW;
                        end
                    end
                    PH_LOW: begin
                        if (!lo && !hi) begin
                            state     <= PH_DEAD;
                            cnt       <= CNT_W'(1);
                            from_high <= 1'b0;
                        end else if (hi) begin
                            state <= PH_HIGH;
                        end
                    end
                    PH_DEAD: begin
                        if (hi)      state <= PH_HIGH;
                        else if (lo) state <= PH_LOW;
                        else if (cnt != CNT_MAX)
                            cnt <= cnt + CNT_W'(1);
                    end
                    default: state <= PH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ac_motor_gate_monitor.sv
// Bridge gate monitor: registers gates, decodes vector, latches faults.
// Ports: clk, reset, enable, delay, s_high, s_low, fault_clear ->
//        vector, vector_valid, dead_time, dead_strobe, fault, fault_code, fault_phase.
module ac_motor_gate_monitor
    import ac_motor_gate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOL   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         delay,
    input  logic [2:0]         s_high,
    input  logic [2:0]         s_low,
    input  logic               fault_clear,
    output logic [2:0]         vector,
    output logic               vector_valid,
    output logic [3*CNT_W-1:0] dead_time,
    output logic [2:0]         dead_strobe,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         fault_phase
);

    logic [2:0]   sh_q;
    logic [2:0]   sl_q;
    logic [2:0]   shoot_v;
    logic [2:0]   dead_v;
    logic [2:0]   highs;
    logic [2:0]   cond;
    logic [2:0]   vec_q;
    logic         any_evt;
    logic         can_latch;
    phase_state_t st [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
            sl_q <= '0;
        end else begin
            sh_q <= s_high;
            sl_q <= s_low;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ph
        ac_motor_gate_phase_monitor #(
            .CNT_W (CNT_W),
            .TOL   (TOL)
        ) u_ph (
            .clk       (clk),
            .reset     (reset),
            .hi        (sh_q[g]),
            .lo        (sl_q[g]),
            .delay     (delay),
            .state     (st[g]),
            .dead_time (dead_time[g*CNT_W +: CNT_W]),
            .strobe    (dead_strobe[g]),
            .shoot_evt (shoot_v[g]),
            .dead_evt  (dead_v[g])
        );
        assign highs[g] = (st[g] == PH_HIGH);
        assign cond[g]  = (st[g] == PH_HIGH) || (st[g] == PH_LOW);
    end

    // Vector follows the leg states while all conduct, else holds.
    assign vector_valid = &cond;
    assign vector       = vector_valid ? highs : vec_q;

    always_ff @(posedge clk) begin
        if (reset) vec_q <= '0;
        else       vec_q <= vector;
    end

    // A clear in the same cycle as an event lets the event re-latch.
    assign any_evt   = |(shoot_v | dead_v);
    assign can_latch = enable && any_evt && (!fault || fault_clear);

    always_ff @(posedge clk) begin
        if (reset) begin
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            fault_phase <= '0;
        end else if (can_latch) begin
            fault       <= 1'b1;
            fault_phase <= shoot_v | dead_v;
            if (|shoot_v && |dead_v) fault_code <= FAULT_BOTH;
            else if (|shoot_v)       fault_code <= FAULT_SHOOT;
            else                     fault_code <= FAULT_DEAD;
        end else if (fault_clear) begin
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
            fault_phase <= '0;
        end
    end

endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// Directed bench for the bridge gate monitor.
// Drives gate patterns between edges and checks outputs after edges.
module tb_ac_motor_gate_monitor;

    localparam int CNT_W = 9;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [7:0]         delay;
    logic [2:0]         s_high;
    logic [2:0]         s_low;
    logic               fault_clear;
    logic [2:0]         vector;
    logic               vector_valid;
    logic [3*CNT_W-1:0] dead_time;
    logic [2:0]         dead_strobe;
    logic               fault;
    logic [1:0]         fault_code;
    logic [2:0]         fault_phase;

    int total = 0;
    int bad   = 0;

    ac_motor_gate_monitor #(.CNT_W(CNT_W), .TOL(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .delay        (delay),
        .s_high       (s_high),
        .s_low        (s_low),
        .fault_clear  (fault_clear),
        .vector       (vector),
        .vector_valid (vector_valid),
        .dead_time    (dead_time),
        .dead_strobe  (dead_strobe),
        .fault        (fault),
        .fault_code   (fault_code),
        .fault_phase  (fault_phase)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fault(input string tag, input logic f,
                             input logic [1:0] c, input logic [2:0] p);
        chk({tag, "_f"}, {31'd0, fault}, {31'd0, f});
        chk({tag, "_c"}, {30'd0, fault_code}, {30'd0, c});
        chk({tag, "_p"}, {29'd0, fault_phase}, {29'd0, p});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; delay = 8'd5;
        s_high = '0; s_low = '0; fault_clear = 1'b0;
        tick(2);
        chk("rst_vec", {29'd0, vector}, 32'd0);
        chk("rst_vv", {31'd0, vector_valid}, 32'd0);
        chk("rst_dt", {5'd0, dead_time}, 32'd0);
        chk("rst_ds", {29'd0, dead_strobe}, 32'd0);
        chk_fault("rst", 1'b0, 2'd0, 3'd0);
        reset = 1'b0;
        tick(1);

        // Phase 1: high, 5 dead cycles, low
        s_high = 3'b001; tick(1);
        s_high = 3'b000; tick(5);
        s_low = 3'b001; tick(2);
        chk("p1_dt", {23'd0, dead_time[8:0]}, 32'd5);
        chk("p1_ds", {29'd0, dead_strobe}, 32'd1);
        chk_fault("p1", 1'b0, 2'd0, 3'd0);
        tick(1);
        chk("p1_ds_once", {29'd0, dead_strobe}, 32'd0);

        // Phase 2: low, 3 dead cycles, high -> short dead time
        s_low = 3'b011; tick(1);
        s_low = 3'b001; tick(3);
        s_high = 3'b010; tick(2);
        chk("p2_dt", {23'd0, dead_time[17:9]}, 32'd3);
        chk_fault("p2", 1'b1, 2'd2, 3'b010);
        tick(3);
        chk_fault("p2_hold", 1'b1, 2'd2, 3'b010);

        // Clear, then shoot-through on phase 3
        fault_clear = 1'b1; tick(1);
        fault_clear = 1'b0;
        chk_fault("clr1", 1'b0, 2'd0, 3'd0);
        s_high = 3'b110; s_low = 3'b101; tick(1);
        s_high = 3'b010; s_low = 3'b001; tick(1);
        chk_fault("shoot", 1'b1, 2'd1, 3'b100);

        // Same stimulus with monitoring disabled
        fault_clear = 1'b1; tick(1);
        fault_clear = 1'b0;
        enable = 1'b0;
        s_high = 3'b110; s_low = 3'b101; tick(1);
        s_high = 3'b010; s_low = 3'b001; tick(2);
        chk_fault("shoot_dis", 1'b0, 2'd0, 3'd0);
        enable = 1'b1;

        // Phase 1 shoot-through while phase 2 ends a 2-cycle dead time
        delay = 8'd8;
        s_high = 3'b000; tick(2);
        s_high = 3'b001; s_low = 3'b011; tick(1);
        s_high = 3'b000; s_low = 3'b011; tick(1);
        chk_fault("both", 1'b1, 2'd3, 3'b011);
        chk("both_dt", {23'd0, dead_time[17:9]}, 32'd2);
        fault_clear = 1'b1; tick(1);
        fault_clear = 1'b0;
        chk_fault("clr2", 1'b0, 2'd0, 3'd0);

        // Vector decode: highs=101
        delay = 8'd0;
        s_high = 3'b101; s_low = 3'b010; tick(2);
        chk("vec", {29'd0, vector}, 32'd5);
        chk("vv", {31'd0, vector_valid}, 32'd1);
        chk_fault("vec", 1'b0, 2'd0, 3'd0);
        s_low = 3'b000; tick(2);
        chk("vv_dead", {31'd0, vector_valid}, 32'd0);
        chk("vec_hold", {29'd0, vector}, 32'd5);

        // Long dead time on phase 2 saturates the counter
        delay = 8'd5;
        tick(600);
        s_high = 3'b111; tick(2);
        chk("sat_dt", {23'd0, dead_time[17:9]}, 32'd511);
        chk("sat_ds", {29'd0, dead_strobe}, 32'b010);
        chk_fault("sat", 1'b0, 2'd0, 3'd0);
        chk("sat_vec", {29'd0, vector}, 32'd7);

        // Reset in the middle of a dead time
        s_high = 3'b101; tick(4);
        chk("pre_rst_vv", {31'd0, vector_valid}, 32'd0);
        reset = 1'b1; fault_clear = 1'b1; tick(1);
        chk("mid_vec", {29'd0, vector}, 32'd0);
        chk("mid_vv", {31'd0, vector_valid}, 32'd0);
        chk("mid_dt", {5'd0, dead_time}, 32'd0);
        chk("mid_ds", {29'd0, dead_strobe}, 32'd0);
        chk_fault("mid", 1'b0, 2'd0, 3'd0);
        reset = 1'b0; fault_clear = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac_motor_gate_monitor.md
Name: ac_motor_gate_monitor

Overview:
- Receiving end of the switch-delay gate interface.
- Observes the six gate signals (three high/low pairs) driven into the inverter bridge and decodes them back into the applied switching vector.
- Measures the dead time on every commutation and checks it against the commanded delay. Detects shoot-through and short dead time.
- Latches a sticky fault that upstream control uses to drop enable. Sits beside the three switch-delay instances and is also used as a bench checker.

Parameters:
- CNT_W, 9, width of per-phase dead-time counter; counter saturates at 2**CNT_W-1
- TOL, 1, allowed shortfall in clk cycles below commanded delay before a dead-time fault

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  monitoring enable; when low, no new faults are raised
- delay  input  8  commanded dead time in clk cycles (same value fed to switch-delay blocks)
- s_high  input  3  high-side gates, bit0 = phase 1
- s_low  input  3  low-side gates, bit0 = phase 1
- fault_clear  input  1  clears sticky fault
- vector  output  3  decoded bridge vector, bit n = 1 if phase n+1 high side conducting
- vector_valid  output  1  all three phases in a conducting state (none in dead time)
- dead_time  output  3*CNT_W  last measured dead time per phase, phase 1 in LSBs
- dead_strobe  output  3  one-cycle pulse per phase when its dead_time field updates
- fault  output  1  sticky fault flag
- fault_code  output  2  0 none, 1 shoot-through, 2 dead time short, 3 both in same cycle
- fault_phase  output  3  phases involved in first latched fault

Behaviour:
- Reset: all outputs 0. Phase states go to IDLE, counters 0. Reset overrides fault_clear and everything else.
- Input stage: s_high/s_low registered once. All decisions use the registered copy. A pattern present at posedge k is reflected in outputs after posedge k+1 (latency 2 edges).
- Per-phase FSM, states IDLE, HIGH, DEAD, LOW. Pair decoding: 10 = high, 01 = low, 00 = off, 11 = both.
  - IDLE: 10 goes to HIGH, 01 goes to LOW. No dead-time check on leaving IDLE.
  - HIGH/LOW: 00 goes to DEAD, counter cleared to 1. The FSM remembers the origin side.
  - HIGH/LOW direct to the opposite side (no 00 cycle): measured dead time is 0 and the dead-time check is applied.
  - DEAD: counter increments each 00 cycle, saturating.
    - Opposite side appears: dead_time field = counter, dead_strobe pulses, check applied, then go to HIGH or LOW.
    - Same side reappears: return to the origin state, no measurement.
  - Any state with 11: shoot-through event. FSM goes to IDLE.
- Dead-time check: fails if measured + TOL < delay, computed in CNT_W+1 bits, unsigned. delay = 0 never fails.
- Fault latch: if enable is high and any phase has an event, and fault is 0, then fault = 1 and fault_phase = OR of the phases with an event that cycle.
  - fault_code = 1 for shoot-through only, 2 for short dead time only, 3 when both occur in the same cycle.
  - Later events do not change fault, code, or phase until cleared.
- fault_clear: clears fault, fault_code and fault_phase. If an event occurs in the same cycle, the event wins and the fault is re-latched.
- vector/vector_valid: vector_valid = 1 when all phases are in HIGH or LOW. vector updates only when valid and holds its value otherwise.
- enable low: FSMs and measurements keep running; fault latching is suppressed; an existing fault is held.
- A delay change mid-dead-time uses the delay value at the cycle the opposite side appears.

Decomposition:
- Package ac_motor_gate_pkg:
  - phase state encoding (IDLE, HIGH, DEAD, LOW)
  - fault code constants FAULT_NONE, FAULT_SHOOT, FAULT_DEAD, FAULT_BOTH
  - default CNT_W
- Sub-module ac_motor_gate_phase_monitor, instantiated three times. Contains the FSM, counter and check. Outputs state, dead_time, strobe, shoot_evt, dead_evt.
- The top contains the input registers, vector decode and fault latch.

Test Plan:
- Reset then delay=5, phase 1 sequence 10, 00×5, 01 -> dead_time[0]=5, dead_strobe[0] pulses once, fault=0.
- delay=5, phase 2 sequence 01, 00×3, 10 -> fault=1, fault_code=2, fault_phase=3'b010; holds after phase 2 returns to a legal pattern.
- Phase 3 pattern 11 for one cycle with enable=1 -> fault=1, code=1, phase=3'b100 two edges later. With enable=0 the same stimulus gives fault=0.
- Same cycle: phase 1 has 11 while phase 2 completes a dead time of 2 with delay=8 -> code=3, phase=3'b011. fault_clear pulsed with no new events -> all fault outputs 0.
- All phases legal with highs=3'b101 -> vector=3'b101, vector_valid=1. Phase 2 enters dead time -> vector_valid=0, vector holds 3'b101.
- Dead time of 600 cycles with CNT_W=9 -> dead_time field saturates at 511, no fault. Reset asserted mid-dead-time -> all outputs 0 on the next edge.
